tetris_cmd_encoder: RTL and testbench

TETRIS_CMD_ENCODER -- requirements
Module: tetris_cmd_encoder

---
 rtl/tetris_cmd_encoder_if.sv | 9 +
 rtl/tetris_cmd_encoder.sv | 178 +++++++++++++++++
 tb/tb_tetris_cmd_encoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tetris_cmd_encoder_if.sv
// Queue-head command handshake between the encoder and the game logic.
interface tetris_cmd_encoder_if;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_cmd_encoder.sv
// Turns debounced buttons, UART keystrokes and a gravity timer into a queue of
// game commands, one push per cycle under fixed priority.
module tetris_cmd_encoder #(
  parameter int QSIZE     = 16,
  parameter int DOWN_TICK = 25_000_000,
  parameter int DB_TICK   = 500_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             usr_btn,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   gravity_en,
  input  logic                   flush,
  tetris_cmd_encoder_if.master   cmd_if,
  output logic [$clog2(QSIZE):0] q_count,
  output logic                   overflow
);

  localparam int AW  = $clog2(QSIZE);
  localparam int DBW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
  localparam int GW  = (DOWN_TICK > 1) ? $clog2(DOWN_TICK) : 1;

  typedef enum logic [7:0] {
    CMD_NONE       = 8'd0,
    CMD_LEFT       = 8'd4,
    CMD_RIGHT      = 8'd5,
    CMD_DOWN       = 8'd6,
    CMD_DROP       = 8'd7,
    CMD_HOLD       = 8'd8,
    CMD_ROTATE     = 8'd9,
    CMD_ROTATE_REV = 8'd10,
    CMD_BAR        = 8'd11
  } cmd_e;

  // ---------------- button synchronizers and debouncers ----------------
  logic [3:0] sync1_reg, sync2_reg;
  logic [3:0] btn_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= usr_btn;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic           level_reg;
      logic [DBW-1:0] cnt_reg;
      logic           settle;

      assign settle      = (sync2_reg[gi] != level_reg) && (cnt_reg == DBW'(DB_TICK - 1));
      assign btn_evt[gi] = settle && sync2_reg[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (settle) begin
          level_reg <= sync2_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // ---------------- gravity timer ----------------
  logic [GW-1:0] grav_cnt_reg;
  logic          grav_evt;

  assign grav_evt = gravity_en && (grav_cnt_reg == GW'(DOWN_TICK - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           grav_cnt_reg <= '0;
    else if (flush || !gravity_en || grav_evt) grav_cnt_reg <= '0;
    else                                    grav_cnt_reg <= grav_cnt_reg + 1'b1;
  end

  // ---------------- UART keystroke decode ----------------
  cmd_e rx_code;
  logic uart_evt;

  always_comb begin
    rx_code = CMD_NONE;
    case (rx_data)
      8'h61:   rx_code = CMD_LEFT;
      8'h64:   rx_code = CMD_RIGHT;
      8'h73:   rx_code = CMD_DOWN;
      8'h20:   rx_code = CMD_DROP;
      8'h63:   rx_code = CMD_HOLD;
      8'h77:   rx_code = CMD_ROTATE;
      8'h71:   rx_code = CMD_ROTATE_REV;
      8'h62:   rx_code = CMD_BAR;
      default: rx_code = CMD_NONE;
    endcase
  end

  assign uart_evt = rx_valid && (rx_code != CMD_NONE);

  // ---------------- pending flags and arbitration ----------------
  // Source index doubles as priority: 0 = UART (highest) ... 5 = gravity.
  logic [5:0] src_evt, pend_reg, win, clear, accept;
  logic       push, pop, full;
  cmd_e       uart_code_reg, push_code;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  assign src_evt = {grav_evt, btn_evt, uart_evt};
  assign win     = pend_reg & (~pend_reg + 6'd1);
  assign full    = (count_reg == (AW+1)'(QSIZE));
  assign pop     = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign push    = (|pend_reg) && (!full || pop);
  assign clear   = push ? win : 6'd0;
  // A flag being consumed this cycle can take a fresh event; otherwise it is lost.
  assign accept  = src_evt & ~(pend_reg & ~clear);

  always_comb begin
    push_code = CMD_NONE;
    if      (win[0]) push_code = uart_code_reg;
    else if (win[1]) push_code = CMD_LEFT;
    else if (win[2]) push_code = CMD_RIGHT;
    else if (win[3]) push_code = CMD_ROTATE;
    else if (win[4]) push_code = CMD_DROP;
    else if (win[5]) push_code = CMD_DOWN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg      <= '0;
      uart_code_reg <= CMD_NONE;
      overflow      <= 1'b0;
    end else if (flush) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= (pend_reg & ~clear) | accept;
      if (accept[0]) uart_code_reg <= rx_code;
      if (|(src_evt & ~accept)) overflow <= 1'b1;
    end
  end

  // ---------------- circular command queue ----------------
  logic [7:0] mem [QSIZE];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign cmd_if.cmd_valid = (count_reg != '0);
  assign cmd_if.cmd       = cmd_if.cmd_valid ? mem[rd_ptr_reg] : CMD_NONE;
  assign q_count          = count_reg;

endmodule

// File: tb/tb_tetris_cmd_encoder.sv
// Directed bench for tetris_cmd_encoder with short timer constants.
module tb_tetris_cmd_encoder;
  localparam int QSIZE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] usr_btn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       gravity_en;
  logic       flush;
  logic [2:0] q_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n_grav;
  int t_grav [3];
  int exp_order [6];

  tetris_cmd_encoder_if cif ();

  tetris_cmd_encoder #(.QSIZE(QSIZE), .DOWN_TICK(10), .DB_TICK(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .usr_btn    (usr_btn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .gravity_en (gravity_en),
    .flush      (flush),
    .cmd_if     (cif),
    .q_count    (q_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop1();
    cif.cmd_ready = 1'b1;
    @(negedge clk);
    cif.cmd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; usr_btn = '0; rx_valid = 1'b0; rx_data = '0;
    gravity_en = 1'b0; flush = 1'b0; cif.cmd_ready = 1'b0;
    t_grav = '{0, 0, 0};
    exp_order = '{4, 5, 6, 8, 11, 6};
    step(2);
    chk("rst_valid", cif.cmd_valid, 0);
    chk("rst_cmd", cif.cmd, 0);
    chk("rst_count", q_count, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(1);

    // UART decode, unmapped bytes dropped
    rx("a"); rx("w"); rx("z"); rx(" "); rx("A");
    step(3);
    chk("uart_count", q_count, 3);
    chk("uart_ovf", overflow, 0);
    chk("uart_head0", cif.cmd, 4);
    pop1();
    chk("uart_head1", cif.cmd, 9);
    pop1();
    chk("uart_head2", cif.cmd, 7);
    pop1();
    chk("uart_empty", cif.cmd_valid, 0);

    // debounce: short pulse rejected, long press gives exactly one RIGHT
    usr_btn[1] = 1'b1; step(3); usr_btn[1] = 1'b0; step(10);
    chk("btn_short", q_count, 0);
    usr_btn[1] = 1'b1; step(10); usr_btn[1] = 1'b0; step(10);
    chk("btn_count", q_count, 1);
    chk("btn_cmd", cif.cmd, 5);
    pop1();
    chk("btn_empty", cif.cmd_valid, 0);

    // gravity: DOWN every 10 cycles, first visible one cycle after the wrap
    gravity_en = 1'b1; cif.cmd_ready = 1'b1; n_grav = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (cif.cmd_valid) begin
        chk("grav_cmd", cif.cmd, 6);
        if (n_grav < 3) t_grav[n_grav] = i;
        n_grav++;
      end
    end
    gravity_en = 1'b0; cif.cmd_ready = 1'b0;
    chk("grav_n", n_grav, 3);
    chk("grav_first", t_grav[0], 11);
    chk("grav_gap1", t_grav[1] - t_grav[0], 10);
    chk("grav_gap2", t_grav[2] - t_grav[1], 10);

    // full queue: UART and gravity both held pending, then drained in priority order
    gravity_en = 1'b1;
    rx("a"); rx("d"); rx("s"); rx("c");
    step(5);
    rx("b");
    gravity_en = 1'b0;
    step(3);
    chk("full_count", q_count, 4);
    chk("full_ovf", overflow, 0);
    cif.cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("drain_cmd", cif.cmd, exp_order[k]);
      @(negedge clk);
    end
    cif.cmd_ready = 1'b0;
    chk("drain_count", q_count, 0);
    chk("drain_ovf", overflow, 0);

    // overflow on a second 'a' while the first is still pending, then flush
    rx("a"); rx("d"); rx("s"); rx("c");
    step(2);
    rx("a");
    step(1);
    chk("ovf_before", overflow, 0);
    rx("a");
    chk("ovf_set", overflow, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_count", q_count, 0);
    chk("flush_valid", cif.cmd_valid, 0);
    chk("flush_ovf", overflow, 1);
    step(3);
    chk("flush_pend", q_count, 0);

    // asynchronous reset mid-stream
    rx("q");
    step(2);
    chk("pre_rst_cmd", cif.cmd, 10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", cif.cmd_valid, 0);
    chk("arst_cmd", cif.cmd, 0);
    chk("arst_count", q_count, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rx("w");
    step(2);
    chk("post_rst_cmd", cif.cmd, 9);
    chk("post_rst_count", q_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
